// File: rtl/demux_4_pkg.sv
// Shared constants for the buffered 1-to-4 distributor: selector codes,
// holding-slot states and the default datapath width.
package demux_4_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    localparam logic [1:0] SEL_ONE   = 2'b00;
    localparam logic [1:0] SEL_TWO   = 2'b01;
    localparam logic [1:0] SEL_THREE = 2'b10;
    localparam logic [1:0] SEL_FOUR  = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register between the distributor and a single consumer.
// The full flag is the slot's state and doubles as its observable status.
module demux_slot
    import demux_4_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  ready_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full
);

    slot_state_t state;

    // A load wins over a drain: drain plus load in one cycle stays FULL with the new word.
    // Data is only written on load, so an emptied slot keeps its last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= SLOT_EMPTY;
            data_out <= '0;
        end else if (load) begin
            state    <= SLOT_FULL;
            data_out <= data_in;
        end else if (state == SLOT_FULL && ready_in) begin
            state    <= SLOT_EMPTY;
        end
    end

    assign full      = (state == SLOT_FULL);
    assign valid_out = full;

endmodule

// File: rtl/demux_4_buffered.sv
// Registered 1-to-4 distributor: selector steers each accepted word into one
// of four independent holding slots, so a stalled consumer blocks only its own traffic.
module demux_4_buffered
    import demux_4_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             selector,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [DATA_WIDTH-1:0]  input_data,
    output logic [3:0]             output_valid,
    input  logic [3:0]             output_ready,
    output logic [DATA_WIDTH-1:0]  output_one,
    output logic [DATA_WIDTH-1:0]  output_two,
    output logic [DATA_WIDTH-1:0]  output_three,
    output logic [DATA_WIDTH-1:0]  output_four,
    output logic [COUNT_WIDTH-1:0] accept_count
);

    // Handshake: a word moves on any rising edge where valid and ready are both 1;
    // ready never looks at valid, and the producer may change its word while ready=0.
    logic [3:0]            full;
    logic [3:0]            load;
    logic                  accept;
    logic [DATA_WIDTH-1:0] slot_data [4];

    assign input_ready = !full[selector] || output_ready[selector];
    assign accept      = input_valid && input_ready;

    always_comb begin
        load = '0;
        if (accept) begin
            case (selector)
                SEL_ONE:   load[0] = 1'b1;
                SEL_TWO:   load[1] = 1'b1;
                SEL_THREE: load[2] = 1'b1;
                SEL_FOUR:  load[3] = 1'b1;
                default:   load    = '0;
            endcase
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_slot
        demux_slot #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (load[i]),
            .data_in  (input_data),
            .ready_in (output_ready[i]),
            .valid_out(output_valid[i]),
            .data_out (slot_data[i]),
            .full     (full[i])
        );
    end

    assign output_one   = slot_data[0];
    assign output_two   = slot_data[1];
    assign output_three = slot_data[2];
    assign output_four  = slot_data[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accept_count <= '0;
        end else if (accept) begin
            accept_count <= accept_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_demux_4_buffered.sv
// Bench for demux_4_buffered: directed vector table, multi-cycle corner cases
// and random traffic checked against a per-destination queue model.
module tb_demux_4_buffered;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic [1:0]    selector;
    logic          input_valid;
    logic          input_ready;
    logic [DW-1:0] input_data;
    logic [3:0]    output_valid;
    logic [3:0]    output_ready;
    logic [DW-1:0] output_one, output_two, output_three, output_four;
    logic [CW-1:0] accept_count;

    demux_4_buffered #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .selector    (selector),
        .input_valid (input_valid),
        .input_ready (input_ready),
        .input_data  (input_data),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .output_one  (output_one),
        .output_two  (output_two),
        .output_three(output_three),
        .output_four (output_four),
        .accept_count(accept_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    // A destination is FULL exactly when its queue holds a word.
    logic [DW-1:0] exp_q [4][$];
    logic [DW-1:0] last_word [4];
    logic [CW-1:0] m_count;
    int            act_drain_cnt [4];
    logic [DW-1:0] act_last_drain [4];
    logic          smp_rdy;
    int            n_vec;
    int            n_fail;

    typedef struct {
        logic [1:0]    sel;
        logic          vld;
        logic [DW-1:0] data;
        logic [3:0]    rdy;
        logic          exp_rdy;
        logic [3:0]    exp_valid;
        logic [CW-1:0] exp_count;
    } vec_t;
    vec_t vq[$];

    task automatic check(input string name, input int idx, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] out_word(input int i);
        case (i)
            0:       return output_one;
            1:       return output_two;
            2:       return output_three;
            default: return output_four;
        endcase
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            last_word[i] = '0;
        end
        m_count = '0;
    endtask

    task automatic check_state();
        for (int i = 0; i < 4; i++) begin
            check("output_valid", i, DW'(output_valid[i]), DW'(exp_q[i].size() > 0));
            check("output_data", i, out_word(i),
                  (exp_q[i].size() > 0) ? exp_q[i][0] : last_word[i]);
        end
        check("accept_count", 0, DW'(accept_count), DW'(m_count));
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic [1:0] sel, input logic vld, input logic [DW-1:0] d,
                         input logic [3:0] rdy);
        logic model_rdy;
        @(negedge clk);
        selector = sel; input_valid = vld; input_data = d; output_ready = rdy;
        #1;
        smp_rdy   = input_ready;
        model_rdy = (exp_q[sel].size() == 0) || rdy[sel];
        check("input_ready", int'(sel), DW'(input_ready), DW'(model_rdy));
        for (int i = 0; i < 4; i++) begin
            if (rdy[i] && output_valid[i]) begin
                act_drain_cnt[i]++;
                act_last_drain[i] = out_word(i);
            end
            if (rdy[i] && exp_q[i].size() > 0) void'(exp_q[i].pop_front());
        end
        if (vld && model_rdy) begin
            exp_q[sel].push_back(d);
            last_word[sel] = d;
            m_count++;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        input_valid = 1'b0; selector = '0; input_data = '0; output_ready = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic add_vec(input logic [1:0] sel, input logic vld, input logic [DW-1:0] d,
                           input logic [3:0] rdy, input logic er, input logic [3:0] ev,
                           input logic [CW-1:0] ec);
        vec_t v;
        v.sel = sel; v.vld = vld; v.data = d; v.rdy = rdy;
        v.exp_rdy = er; v.exp_valid = ev; v.exp_count = ec;
        vq.push_back(v);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_vec = 0; n_fail = 0;
        for (int i = 0; i < 4; i++) begin
            act_drain_cnt[i] = 0;
            act_last_drain[i] = '0;
        end
        reset = 1'b0; selector = '0; input_valid = 1'b0; input_data = '0; output_ready = '0;
        model_clear();
        do_reset();

        // Reset then idle: every selector sees ready.
        for (int s = 0; s < 4; s++) begin
            selector = 2'(s);
            #1;
            check("idle_input_ready", s, DW'(input_ready), DW'(1));
        end
        check_state();

        // sel vld data rdy | exp_rdy exp_valid(after edge) exp_count(after edge)
        add_vec(2'b00, 1, 32'h1111_1111, 4'b0000, 1, 4'b0001, 4'd1);
        add_vec(2'b01, 1, 32'h2222_2222, 4'b0000, 1, 4'b0011, 4'd2);
        add_vec(2'b10, 1, 32'h3333_3333, 4'b0000, 1, 4'b0111, 4'd3);
        add_vec(2'b11, 1, 32'h4444_4444, 4'b0000, 1, 4'b1111, 4'd4);
        add_vec(2'b10, 1, 32'h5555_5555, 4'b0000, 0, 4'b1111, 4'd4);
        add_vec(2'b00, 0, 32'h0,         4'b0001, 1, 4'b1110, 4'd4);
        add_vec(2'b00, 1, 32'hA5A5_A5A5, 4'b0000, 1, 4'b1111, 4'd5);
        add_vec(2'b01, 1, 32'h6666_6666, 4'b0000, 0, 4'b1111, 4'd5);
        add_vec(2'b10, 0, 32'h0,         4'b0100, 1, 4'b1011, 4'd5);
        add_vec(2'b10, 1, 32'h0000_0001, 4'b0000, 1, 4'b1111, 4'd6);
        add_vec(2'b10, 1, 32'h0000_0002, 4'b0100, 1, 4'b1111, 4'd7);
        add_vec(2'b11, 1, 32'h7777_7777, 4'b0000, 0, 4'b1111, 4'd7);

        foreach (vq[k]) begin
            cycle(vq[k].sel, vq[k].vld, vq[k].data, vq[k].rdy);
            check("vec_input_ready", k, DW'(smp_rdy), DW'(vq[k].exp_rdy));
            check("vec_output_valid", k, DW'(output_valid), DW'(vq[k].exp_valid));
            check("vec_accept_count", k, DW'(accept_count), DW'(vq[k].exp_count));
        end
        check("hold_output_one", 0, output_one, 32'hA5A5_A5A5);
        check("hold_output_two", 1, output_two, 32'h2222_2222);
        check("pass_output_three", 2, output_three, 32'h0000_0002);
        check("pass_drains_three", 2, DW'(act_drain_cnt[2]), DW'(2));
        check("pass_drained_word", 2, act_last_drain[2], 32'h0000_0001);

        // Counter wraps: 17 accepts on a 4-bit counter read back as 1.
        do_reset();
        for (int n = 0; n < 17; n++) cycle(2'($urandom_range(0, 3)), 1'b1, $urandom, 4'hF);
        check("wrap_accept_count", 0, DW'(accept_count), DW'(1));

        // Random traffic against the queue model.
        for (int n = 0; n < 400; n++)
            cycle(2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, $urandom,
                  4'($urandom_range(0, 15)));

        // Reset with slot four FULL and a blocked write pending.
        cycle(2'b11, 1'b0, '0, 4'b1000);
        cycle(2'b11, 1'b1, 32'h4444_4444, 4'b0000);
        selector = 2'b11; input_valid = 1'b1; input_data = 32'hDEAD_BEEF; output_ready = 4'b0000;
        #2;
        reset = 1'b0;
        #1;
        check("async_output_valid", 0, DW'(output_valid), DW'(0));
        check("async_output_four", 3, output_four, DW'(0));
        check("async_input_ready", 3, DW'(input_ready), DW'(1));
        check("async_accept_count", 0, DW'(accept_count), DW'(0));
        model_clear();
        @(posedge clk);
        @(negedge clk);
        input_valid = 1'b0;
        reset = 1'b1;
        for (int n = 0; n < 3; n++) cycle(2'($urandom_range(0, 3)), 1'b0, '0, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
